multicycle_ctrl_fsm: RTL
========================

# multicycle_ctrl_fsm

Main control state machine for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select, including the 2-bit ALU operation class consumed by the ALU control unit. That unit combines the class with the funct field to form the 3-bit ALU control.

## Interface
- JUMP_EN, default 1: when 0, opcode `j` is treated as illegal.
- iclk  in  1  clock; all state changes on the rising edge.
- irst_n  in  1  asynchronous, active-low reset.
- iopcode  in  6  instruction register bits [31:26]; sampled only in DECODE.
- oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg, oIRWrite, oALUSrcA, oRegWrite, oRegDst  out  1 each  datapath controls.
- oPCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- oALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- oALUOp  out  2  00 = add, 01 = subtract, 10 = use funct; 11 is never driven.
- oIllegal  out  1  one-cycle pulse on an unsupported opcode.
- oState  out  4  current state encoding, for debug and testbench.

## Operation
- Moore machine: outputs decode from the state register only; any output not listed for a state is 0.
- While irst_n = 0, all outputs are forced to 0 and oState = 0.
- State encodings, outputs and next state:
  - FETCH (0): MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1. Next: DECODE.
  - DECODE (1): ALUSrcB=11. Next state by iopcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP if JUMP_EN = 1
    - anything else → FETCH, with oIllegal=1 during this DECODE cycle.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10. Next: MEMRD for lw, MEMWR for sw. The choice uses the opcode latched in DECODE, held in an internal 1-bit register.
  - MEMRD (3): MemRead=1, IorD=1. Next: MEMWB.
  - MEMWB (4): MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR (5): MemWrite=1, IorD=1. Next: FETCH.
  - EXEC (6): ALUSrcA=1, ALUOp=10. Next: RTWB.
  - RTWB (7): RegDst=1, RegWrite=1. Next: FETCH.
  - BRANCH (8): ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
  - JUMP (9): PCWrite=1, PCSource=10. Next: FETCH.
- Encodings 10–15 are unreachable. If entered, outputs are all 0 and the next state is FETCH.
- iopcode changes outside DECODE have no effect.

## Timing
- Cycles per instruction, counted from the first FETCH cycle to the next FETCH cycle:
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - j: 3
  - illegal: 2
- oMemWrite and oRegWrite are each high for exactly one cycle per instruction.
- oPCWrite is high only in FETCH and JUMP. oPCWriteCond is high only in BRANCH.
- Reset may be asserted mid-instruction, in any state:
  - outputs drop to 0 asynchronously;
  - the state goes to FETCH asynchronously;
  - no write enable is asserted until after release.
- First rising edge after irst_n rises: the state is already FETCH and the fetch outputs are active during that cycle.
- oIllegal is high for exactly one cycle and is never asserted outside DECODE.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state encodings 0–9;
  - the opcode constants (RTYPE, LW, SW, BEQ, J);
  - the oALUOp class constants (ADD=00, SUB=01, FUNCT=10);
  - the oPCSource and oALUSrcB select constants.
- The ALU control unit imports the same oALUOp constants.
- Single module, no sub-modules:
  - next-state logic in one combinational process;
  - state register with async reset;
  - output decode as a separate combinational process.

## Test plan
- Reset held for 3 cycles in state MEMRD, then released: outputs are 0 during reset, oState=0 after, then FETCH outputs MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- iopcode=100011 (lw): oState sequence 0,1,2,3,4,0; oALUOp=00 in MEMADR; oRegWrite=1 and oMemtoReg=1 only in state 4.
- iopcode=000000 (R-type) then 101011 (sw): R-type gives 0,1,6,7,0 with oALUOp=10 in state 6; sw gives 0,1,2,5,0 with oMemWrite=1 for one cycle.
- iopcode=000100 (beq): 0,1,8,0 with oPCWriteCond=1, oALUOp=01, oPCSource=01 in state 8. iopcode toggled in state 8 has no effect.
- iopcode=000010 with JUMP_EN=1 gives 0,1,9,0 with oPCSource=10. With JUMP_EN=0, or iopcode=111111, the sequence is 0,1,0 with oIllegal=1 in state 1 only.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: FSM state
// encodings, opcodes, ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation class handed to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the main control FSM and the multicycle datapath.
interface multicycle_ctrl_fsm_if;
  logic [5:0] iopcode;
  logic       oPCWrite;
  logic       oPCWriteCond;
  logic       oIorD;
  logic       oMemRead;
  logic       oMemWrite;
  logic       oMemtoReg;
  logic       oIRWrite;
  logic       oALUSrcA;
  logic       oRegWrite;
  logic       oRegDst;
  logic [1:0] oPCSource;
  logic [1:0] oALUSrcB;
  logic [1:0] oALUOp;
  logic       oIllegal;
  logic [3:0] oState;

  // Controller side
  modport master (
    input  iopcode,
    output oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg,
           oIRWrite, oALUSrcA, oRegWrite, oRegDst, oPCSource, oALUSrcB,
           oALUOp, oIllegal, oState
  );

  // Datapath side
  modport slave (
    output iopcode,
    input  oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg,
           oIRWrite, oALUSrcA, oRegWrite, oRegDst, oPCSource, oALUSrcB,
           oALUOp, oIllegal, oState
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS datapath. Moore-style decode of
// the state register; oIllegal is the one output that also looks at the
// opcode, and only during DECODE.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit JUMP_EN = 1'b1
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  multicycle_ctrl_fsm_if.master bus
);

  state_t state;
  state_t state_nxt;
  logic   is_store;   // opcode class latched in DECODE: 1 = sw, 0 = lw
  logic   op_illegal;

  // Next-state selection and unsupported-opcode detection
  always_comb begin
    state_nxt  = S_FETCH;
    op_illegal = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.iopcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J: begin
            if (JUMP_EN) state_nxt = S_JUMP;
            else         op_illegal = 1'b1;
          end
          default:      op_illegal = 1'b1;
        endcase
      end
      S_MEMADR: state_nxt = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_RTWB;
      S_RTWB:   state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // State register and lw/sw latch
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) is_store <= (bus.iopcode == OP_SW);
    end
  end

  // Output decode; reset is folded in so every control drops to 0
  // asynchronously while irst_n is low even though the state reads FETCH.
  always_comb begin
    bus.oPCWrite     = 1'b0;
    bus.oPCWriteCond = 1'b0;
    bus.oIorD        = 1'b0;
    bus.oMemRead     = 1'b0;
    bus.oMemWrite    = 1'b0;
    bus.oMemtoReg    = 1'b0;
    bus.oIRWrite     = 1'b0;
    bus.oALUSrcA     = 1'b0;
    bus.oRegWrite    = 1'b0;
    bus.oRegDst      = 1'b0;
    bus.oPCSource    = PCSRC_ALU;
    bus.oALUSrcB     = SRCB_B;
    bus.oALUOp       = ALUOP_ADD;
    bus.oIllegal     = 1'b0;
    bus.oState       = '0;
    if (irst_n) begin
      bus.oState = state;
      case (state)
        S_FETCH: begin
          bus.oMemRead = 1'b1;
          bus.oIRWrite = 1'b1;
          bus.oALUSrcB = SRCB_FOUR;
          bus.oPCWrite = 1'b1;
        end
        S_DECODE: begin
          bus.oALUSrcB = SRCB_IMMSL2;
          bus.oIllegal = op_illegal;
        end
        S_MEMADR: begin
          bus.oALUSrcA = 1'b1;
          bus.oALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          bus.oMemRead = 1'b1;
          bus.oIorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.oMemtoReg = 1'b1;
          bus.oRegWrite = 1'b1;
        end
        S_MEMWR: begin
          bus.oMemWrite = 1'b1;
          bus.oIorD     = 1'b1;
        end
        S_EXEC: begin
          bus.oALUSrcA = 1'b1;
          bus.oALUOp   = ALUOP_FUNCT;
        end
        S_RTWB: begin
          bus.oRegDst   = 1'b1;
          bus.oRegWrite = 1'b1;
        end
        S_BRANCH: begin
          bus.oALUSrcA     = 1'b1;
          bus.oALUOp       = ALUOP_SUB;
          bus.oPCWriteCond = 1'b1;
          bus.oPCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          bus.oPCWrite  = 1'b1;
          bus.oPCSource = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule
